// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine and its step datapath.
package gcd_pkg;

    // Default operand/result width.
    localparam int GCD_BUS_SIZE = 8;

    // Engine control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

    // Algorithm select: subtractive Euclid or binary (Stein).
    typedef enum logic {
        GCD_SUB = 1'b0,
        GCD_BIN = 1'b1
    } gcd_mode_e;

endpackage

// File: rtl/gcd_step.sv
// Combinational single-step datapath for the GCD engine.
// Given the current operands, the common power-of-two count and the mode,
// it reports equality/zero status and the operand values after one update.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int BusSize = GCD_BUS_SIZE,
    parameter int KW      = $clog2(BusSize + 1)
) (
    input  logic [BusSize-1:0] a,
    input  logic [BusSize-1:0] b,
    input  logic [KW-1:0]      k,
    input  gcd_mode_e          mode,
    output logic [BusSize-1:0] a_nxt,
    output logic [BusSize-1:0] b_nxt,
    output logic [KW-1:0]      k_nxt,
    output logic               eq,
    output logic               zero,
    output logic               inc
);

    logic [BusSize-1:0] a_minus_b;
    logic [BusSize-1:0] b_minus_a;
    logic               a_gt_b;
    logic               a_even;
    logic               b_even;

    // Both differences are formed; only the non-underflowing one is selected.
    assign a_minus_b = a - b;
    assign b_minus_a = b - a;
    assign a_gt_b    = (a > b);
    assign a_even    = ~a[0];
    assign b_even    = ~b[0];

    // Status: a zero operand terminates immediately; equality terminates otherwise.
    assign zero = (a == '0) || (b == '0);
    assign eq   = (a == b);
    assign inc  = !zero && !eq;

    // One update step; operands are held when no update is due.
    always_comb begin
        a_nxt = a;
        b_nxt = b;
        k_nxt = k;
        if (inc) begin
            if (mode == GCD_SUB) begin
                if (a_gt_b) begin
                    a_nxt = a_minus_b;
                end else begin
                    b_nxt = b_minus_a;
                end
            end else begin
                if (a_even && b_even) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + KW'(1);
                end else if (a_even) begin
                    a_nxt = a >> 1;
                end else if (b_even) begin
                    b_nxt = b >> 1;
                end else if (a_gt_b) begin
                    a_nxt = a_minus_b >> 1;
                end else begin
                    b_nxt = b_minus_a >> 1;
                end
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with request/response handshakes.
// Owns the control FSM and all state; the per-cycle arithmetic lives in gcd_step.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int BusSize = GCD_BUS_SIZE,
    parameter int KW      = $clog2(BusSize + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    output logic               ready_o,
    input  logic [BusSize-1:0] A_i,
    input  logic [BusSize-1:0] B_i,
    input  logic               mode_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [BusSize-1:0] result_o,
    output logic [BusSize-1:0] iter_o
);

    gcd_state_e         state_reg,  state_next;
    gcd_mode_e          mode_reg,   mode_next;
    logic [BusSize-1:0] a_reg,      a_next;
    logic [BusSize-1:0] b_reg,      b_next;
    logic [KW-1:0]      k_reg,      k_next;
    logic [BusSize-1:0] iter_reg,   iter_next;
    logic [BusSize-1:0] result_reg, result_next;

    logic [BusSize-1:0] step_a;
    logic [BusSize-1:0] step_b;
    logic [KW-1:0]      step_k;
    logic               step_eq;
    logic               step_zero;
    logic               step_inc;
    logic [BusSize-1:0] a_scaled;

    gcd_step #(
        .BusSize (BusSize),
        .KW      (KW)
    ) u_step (
        .a     (a_reg),
        .b     (b_reg),
        .k     (k_reg),
        .mode  (mode_reg),
        .a_nxt (step_a),
        .b_nxt (step_b),
        .k_nxt (step_k),
        .eq    (step_eq),
        .zero  (step_zero),
        .inc   (step_inc)
    );

    // Binary mode restores the common power of two factored out earlier.
    assign a_scaled = a_reg << k_reg;

    // Handshake flags are pure state decodes; result/iter are masked outside DONE.
    assign ready_o  = (state_reg == IDLE);
    assign valid_o  = (state_reg == DONE);
    assign result_o = valid_o ? result_reg : '0;
    assign iter_o   = valid_o ? iter_reg   : '0;

    // Next-state and datapath update logic.
    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        k_next      = k_reg;
        iter_next   = iter_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    a_next     = A_i;
                    b_next     = B_i;
                    mode_next  = gcd_mode_e'(mode_i);
                    k_next     = '0;
                    iter_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (step_zero) begin
                    result_next = a_reg | b_reg;
                    state_next  = DONE;
                end else if (step_eq) begin
                    result_next = (mode_reg == GCD_BIN) ? a_scaled : a_reg;
                    state_next  = DONE;
                end else if (step_inc) begin
                    a_next    = step_a;
                    b_next    = step_b;
                    k_next    = step_k;
                    iter_next = iter_reg + BusSize'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            mode_reg   <= GCD_SUB;
            a_reg      <= '0;
            b_reg      <= '0;
            k_reg      <= '0;
            iter_reg   <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            k_reg      <= k_next;
            iter_reg   <= iter_next;
            result_reg <= result_next;
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: the driver queues expected responses,
// a monitor on the falling edge pops and compares whenever valid_o rises.
module tb_gcd_engine;

    localparam int W = 8;

    logic         clk_i   = 1'b0;
    logic         rst_ni  = 1'b0;
    logic         start_i = 1'b0;
    logic         mode_i  = 1'b0;
    logic         ready_i = 1'b1;
    logic [W-1:0] A_i     = '0;
    logic [W-1:0] B_i     = '0;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] result_o;
    logic [W-1:0] iter_o;

    gcd_engine #(.BusSize(W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .ready_o  (ready_o),
        .A_i      (A_i),
        .B_i      (B_i),
        .mode_i   (mode_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .iter_o   (iter_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int id;
        int r;
        int it;
    } exp_t;

    typedef struct {
        bit m;
        int a;
        int b;
        int r;
        int it;
    } vec_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   tracking = 0;
    bit   seen_valid = 0;
    int   lat = 0;

    task automatic check(input string name, input int id, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s (op %0d): got %0d, required %0d", name, id, act, req);
    endtask

    // Independent Euclid (modulo form) for expected results.
    function automatic int gcd_mod(input int a, input int b);
        int t;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction

    // Number of update steps each algorithm takes.
    function automatic int step_count(input bit m, input int a, input int b);
        int n;
        n = 0;
        if (a == 0 || b == 0) return 0;
        while (a != b) begin
            if (!m) begin
                if (a > b) a = a - b;
                else       b = b - a;
            end else begin
                if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
                else if (a % 2 == 0) a = a / 2;
                else if (b % 2 == 0) b = b / 2;
                else if (a > b) a = (a - b) / 2;
                else b = (b - a) / 2;
            end
            n++;
        end
        return n;
    endfunction

    // Monitor: latency counted in rising edges since the acceptance edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                tracking   = 0;
                seen_valid = 0;
            end else begin
                if (tracking) lat++;
                if (valid_o && !seen_valid) begin
                    seen_valid = 1;
                    if (!tracking || exp_q.size() == 0) begin
                        check("unexpected_valid", -1, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", e.id, int'(result_o), e.r);
                        check("iter", e.id, int'(iter_o), e.it);
                        check("latency", e.id, lat, e.it + 1);
                    end
                end
                if (valid_o && ready_i) begin
                    tracking   = 0;
                    seen_valid = 0;
                end
                if (start_i && ready_o) begin
                    tracking = 1;
                    lat      = -1;
                end
            end
        end
    end

    // Present one request at the next edge where the engine is ready.
    task automatic issue(input bit m, input int a, input int b, input bit push,
                         input int er, input int ei, input int id);
        int n;
        n = 0;
        while (!ready_o && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!ready_o) check("ready_timeout", id, 0, 1);
        mode_i  = m;
        A_i     = W'(a);
        B_i     = W'(b);
        start_i = 1'b1;
        if (push) exp_q.push_back('{id, er, ei});
        @(posedge clk_i); #1;
        start_i = 1'b0;
        A_i     = W'($urandom);
        B_i     = W'($urandom);
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (!ready_o && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!ready_o) check("done_timeout", id, 0, 1);
    endtask

    task automatic run(input bit m, input int a, input int b, input int er, input int ei, input int id);
        issue(m, a, b, 1'b1, er, ei, id);
        wait_idle(id);
    endtask

    vec_t vecs [16] = '{
        '{1'b0,  12,   8,  4,   2},
        '{1'b1,  12,   8,  4,   4},
        '{1'b0,   0,   0,  0,   0},
        '{1'b0,   0,   9,  9,   0},
        '{1'b0,   9,   0,  9,   0},
        '{1'b1,   0,   0,  0,   0},
        '{1'b1,   0,   9,  9,   0},
        '{1'b1,   9,   0,  9,   0},
        '{1'b0, 255,   1,  1, 254},
        '{1'b1, 255,   1,  1,   7},
        '{1'b0,  48,  18,  6,   4},
        '{1'b1,  48,  18,  6,   5},
        '{1'b0,   7,   7,  7,   0},
        '{1'b1,   7,   7,  7,   0},
        '{1'b1, 128,  64, 64,   7},
        '{1'b0,   1, 255,  1, 254}
    };

    // Stimulus sequence.
    initial begin : driver
        int n;
        int ra;
        int rb;
        bit rm;

        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", 0, int'(ready_o), 1);
        check("rst_valid", 0, int'(valid_o), 0);
        check("rst_result", 0, int'(result_o), 0);
        check("rst_iter", 0, int'(iter_o), 0);
        rst_ni = 1'b1;

        // Directed vectors; the first is presented immediately after reset release.
        for (int i = 0; i < 16; i++) begin
            run(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].it, i);
        end

        // Backpressure: hold the result in DONE while start_i toggles.
        ready_i = 1'b0;
        issue(1'b0, 12, 8, 1'b1, 4, 2, 100);
        n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!valid_o) check("bp_valid_timeout", 100, 0, 1);
        for (int c = 0; c < 5; c++) begin
            start_i = ~start_i;
            A_i     = W'($urandom);
            B_i     = W'($urandom);
            @(posedge clk_i); #1;
            check("bp_result", 100, int'(result_o), 4);
            check("bp_iter", 100, int'(iter_o), 2);
            check("bp_ready", 100, int'(ready_o), 0);
            check("bp_valid", 100, int'(valid_o), 1);
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp_release_ready", 100, int'(ready_o), 1);
        check("bp_release_valid", 100, int'(valid_o), 0);
        check("bp_release_result", 100, int'(result_o), 0);
        run(1'b0, 6, 4, 2, 2, 101);

        // Reset two cycles into a long operation; nothing may follow release.
        issue(1'b0, 255, 1, 1'b0, 0, 0, 200);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_ready", 200, int'(ready_o), 1);
        check("midrst_valid", 200, int'(valid_o), 0);
        check("midrst_result", 200, int'(result_o), 0);
        check("midrst_iter", 200, int'(iter_o), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("postrst_valid", 200, int'(valid_o), 0);
        run(1'b0, 6, 4, 2, 2, 201);

        // Random pairs against the reference functions.
        for (int i = 0; i < 200; i++) begin
            rm = i[0];
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            if (i % 17 == 0) rb = 0;
            run(rm, ra, rb, gcd_mod(ra, rb), step_count(rm, ra, rb), 1000 + i);
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("queue_drained", 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Hard stop if something wedges beyond every bounded wait.
    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
